fc_seq_mac: RTL
===============

FC_SEQ_MAC -- requirements
Module: fc_seq_mac

Interface
REQ-001 SHALL have parameter INPUT_CHANNEL, default 224: dot-product length.
REQ-002 SHALL have parameter BANDWIDTH, default 8: signed width of input, weight and bias elements.
REQ-003 SHALL have parameter OUT_BANDWIDTH, default 24: signed result width.
REQ-004 SHALL have parameter WEIGHT_CHANNEL, default 8: maximum output channels per run.
REQ-005 SHALL derive localparam CNT_W = max(1, clog2(WEIGHT_CHANNEL)).
REQ-006 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-007 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port start, input, 1: run request, sampled only in IDLE.
REQ-009 SHALL have port ch_num, input, CNT_W+1: active output channels N for the run.
REQ-010 SHALL have port relu_en, input, 1: clamps negative results to 0; sampled at start.
REQ-011 SHALL have port input_data, input, signed BANDWIDTH x [INPUT_CHANNEL]: activation vector.
REQ-012 SHALL have port weight_data, input, signed BANDWIDTH x [WEIGHT_CHANNEL][INPUT_CHANNEL]: held stable by the source during RUN.
REQ-013 SHALL have port bias_data, input, signed BANDWIDTH x [WEIGHT_CHANNEL]: held stable during RUN.
REQ-014 SHALL have port busy, output, 1: high while in RUN.
REQ-015 SHALL have port out_valid, output, 1: one-cycle strobe per finished channel.
REQ-016 SHALL have port out_idx, output, CNT_W: channel index qualified by out_valid.
REQ-017 SHALL have port out_data, output, signed OUT_BANDWIDTH: result qualified by out_valid.
REQ-018 SHALL have port output_data, output, signed OUT_BANDWIDTH x [WEIGHT_CHANNEL]: registered result bank.
REQ-019 SHALL have port done, output, 1: one-cycle pulse marking the last channel of a run.

Function
REQ-020 SHALL implement FSM states IDLE and RUN.
REQ-021 IDLE, start=1 at edge E0 SHALL: move to RUN; set cnt=0; latch input_data into an internal register; latch relu_en; latch N.
REQ-022 SHALL take N = ch_num, except ch_num=0 or ch_num>WEIGHT_CHANNEL SHALL give N = WEIGHT_CHANNEL.
REQ-023 In RUN, at each edge Ek (k=1..N), the block SHALL compute channel c=k-1 from the latched input vector as bias_data[c] + sum over i of (input[i]*weight_data[c][i]).
REQ-024 Each product SHALL be 2*BANDWIDTH signed, and accumulation SHALL use full precision of width 2*BANDWIDTH+clog2(INPUT_CHANNEL)+1, with bias sign-extended.
REQ-025 The full sum SHALL saturate to the signed OUT_BANDWIDTH range; ReLU SHALL be applied after saturation.
REQ-026 After edge Ek: output_data[c], out_data=result, out_idx=c, out_valid=1 for one cycle.
REQ-027 At edge EN, the block SHALL also assert done for one cycle and return to IDLE; busy SHALL be low from that cycle.
REQ-028 output_data entries with index >= N SHALL retain their prior values.
REQ-029 start during RUN SHALL be ignored.
REQ-030 start held high SHALL yield back-to-back runs, with the next run accepted at edge EN+1.
REQ-031 Outside the out_valid cycle, out_data and out_idx SHALL hold their last values.

Reset
REQ-032 rstn=0 SHALL immediately force the following, including mid-RUN: state IDLE, cnt 0, busy/out_valid/done 0, out_idx 0, out_data 0, all output_data 0, latched input 0.
REQ-033 After rstn release, the block SHALL produce no out_valid until a new start is accepted.

Verification (IC=4, WC=4, BW=8)
REQ-034 Basic: OBW=24, inputs all 1, weights of channel c all c+1, bias {0,1,2,3}, ch_num=4, start pulse -> out_valid on cycles E1..E4 with out_data 4,9,14,19, done with the fourth, busy high for 4 cycles.
REQ-035 Saturation/ReLU: OBW=16, inputs 127, weights 127 -> 32767. Inputs -128, weights 127 -> -32768. Same with relu_en=1 -> 0.
REQ-036 Partial run: prior bank {7,7,7,7}, ch_num=2 -> two out_valid (idx 0,1), done on idx 1, output_data[2..3] still 7. ch_num=0 -> four results.
REQ-037 Capture and ignore: change input_data and pulse start during RUN -> results use the vector latched at E0, and no extra run occurs.
REQ-038 Continuous start: start held high for 12 cycles -> runs every 5 cycles, done pulses 5 cycles apart.
REQ-039 Reset mid-RUN: rstn low after E2 -> all outputs 0 at once. After release, no out_valid until start.

Source files
------------

// File: rtl/fc_seq_mac.sv
// Sequential fully-connected MAC: one output channel per cycle, a run of N channels takes N cycles after the accept edge.
// No backpressure: results stream out on out_valid; start is only honoured in IDLE, so a held start restarts every N+1 cycles.
module fc_seq_mac #(
  parameter int INPUT_CHANNEL  = 224,
  parameter int BANDWIDTH      = 8,
  parameter int OUT_BANDWIDTH  = 24,
  parameter int WEIGHT_CHANNEL = 8,
  localparam int CNT_W = ($clog2(WEIGHT_CHANNEL) > 1) ? $clog2(WEIGHT_CHANNEL) : 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic [CNT_W:0]                  ch_num,
  input  logic                            relu_en,
  input  logic signed [BANDWIDTH-1:0]     input_data  [INPUT_CHANNEL],
  input  logic signed [BANDWIDTH-1:0]     weight_data [WEIGHT_CHANNEL][INPUT_CHANNEL],
  input  logic signed [BANDWIDTH-1:0]     bias_data   [WEIGHT_CHANNEL],
  output logic                            busy,
  output logic                            out_valid,
  output logic [CNT_W-1:0]                out_idx,
  output logic signed [OUT_BANDWIDTH-1:0] out_data,
  output logic signed [OUT_BANDWIDTH-1:0] output_data [WEIGHT_CHANNEL],
  output logic                            done
);

  localparam int PROD_W = 2 * BANDWIDTH;
  localparam int ACC_W  = PROD_W + $clog2(INPUT_CHANNEL) + 1;
  localparam int SAT_W  = (ACC_W > OUT_BANDWIDTH) ? ACC_W : OUT_BANDWIDTH;
  localparam logic [CNT_W:0] WC_N = (CNT_W + 1)'(WEIGHT_CHANNEL);
  localparam logic signed [SAT_W-1:0] SAT_MAX =
    {{(SAT_W - OUT_BANDWIDTH + 1){1'b0}}, {(OUT_BANDWIDTH - 1){1'b1}}};
  localparam logic signed [SAT_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [CNT_W:0]                  n_q, n_d;
  logic                            relu_q, relu_d;
  logic signed [BANDWIDTH-1:0]     in_q [INPUT_CHANNEL];
  logic signed [BANDWIDTH-1:0]     in_d [INPUT_CHANNEL];
  logic signed [OUT_BANDWIDTH-1:0] bank_q [WEIGHT_CHANNEL];
  logic signed [OUT_BANDWIDTH-1:0] bank_d [WEIGHT_CHANNEL];
  logic                            out_valid_q, out_valid_d;
  logic                            done_q, done_d;
  logic [CNT_W-1:0]                out_idx_q, out_idx_d;
  logic signed [OUT_BANDWIDTH-1:0] out_data_q, out_data_d;

  logic                            last_ch;
  logic signed [PROD_W-1:0]        prod [INPUT_CHANNEL];
  logic signed [ACC_W-1:0]         acc;
  logic signed [SAT_W-1:0]         acc_ext;
  logic signed [OUT_BANDWIDTH-1:0] result;

  assign last_ch = (({1'b0, cnt_q} + (CNT_W + 1)'(1)) == n_q);

  // Full-precision dot product for the channel selected by cnt_q.
  always_comb begin
    for (int i = 0; i < INPUT_CHANNEL; i++) begin
      prod[i] = PROD_W'(in_q[i]) * PROD_W'(weight_data[cnt_q][i]);
    end
  end

  always_comb begin
    acc = ACC_W'(bias_data[cnt_q]);
    for (int i = 0; i < INPUT_CHANNEL; i++) begin
      acc = acc + ACC_W'(prod[i]);
    end
  end

  always_comb begin
    acc_ext = SAT_W'(acc);
    if (acc_ext > SAT_MAX) begin
      result = SAT_MAX[OUT_BANDWIDTH-1:0];
    end else if (acc_ext < SAT_MIN) begin
      result = SAT_MIN[OUT_BANDWIDTH-1:0];
    end else begin
      result = acc_ext[OUT_BANDWIDTH-1:0];
    end
    if (relu_q && result[OUT_BANDWIDTH-1]) begin
      result = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last_ch) state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    n_d         = n_q;
    relu_d      = relu_q;
    in_d        = in_q;
    bank_d      = bank_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    if (state_q == IDLE && start) begin
      cnt_d  = '0;
      in_d   = input_data;
      relu_d = relu_en;
      // Zero or oversized channel counts mean "all channels".
      n_d    = (ch_num == '0 || ch_num > WC_N) ? WC_N : ch_num;
    end else if (state_q == RUN) begin
      bank_d[cnt_q] = result;
      out_data_d    = result;
      out_idx_d     = cnt_q;
      out_valid_d   = 1'b1;
      done_d        = last_ch;
      cnt_d         = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q       <= '0;
      n_q         <= '0;
      relu_q      <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      out_idx_q   <= '0;
      out_data_q  <= '0;
      for (int i = 0; i < INPUT_CHANNEL; i++) in_q[i] <= '0;
      for (int c = 0; c < WEIGHT_CHANNEL; c++) bank_q[c] <= '0;
    end else begin
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      relu_q      <= relu_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
      in_q        <= in_d;
      bank_q      <= bank_d;
    end
  end

  always_comb begin
    busy        = (state_q == RUN);
    out_valid   = out_valid_q;
    done        = done_q;
    out_idx     = out_idx_q;
    out_data    = out_data_q;
    output_data = bank_q;
  end

endmodule
